// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg: shared types and constants for the truth-table capture unit
package gate_tt_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, REPORT = 2'd2} state_t;
  localparam int NUM_VEC = 4;
  localparam int IDX_W = 2;
endpackage

// File: rtl/hold_timer.sv
// hold_timer: down-counter that flags the final cycle of each HOLD-cycle window
module hold_timer #(
  parameter int HOLD = 10,
  parameter int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic last
);
  localparam logic [CNT_W-1:0] TOP = CNT_W'(HOLD - 1);
  logic [CNT_W-1:0] rem;
  assign last = rem == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) rem <= TOP;
    else if (load) rem <= TOP;
    else if (en) rem <= last ? TOP : rem - 1'b1;
  end
endmodule

// File: rtl/gate_tt_capture.sv
// gate_tt_capture: sweeps a two-input gate through all vectors and checks its truth table
module gate_tt_capture #(
  parameter int HOLD = 10,
  parameter int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] table_out,
  output logic [3:0] err_mask,
  output logic       pass
);
  import gate_tt_pkg::*;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_VEC-1:0] table_d, exp_q, exp_d, mask_d;
  logic last, load, at_end;
  hold_timer #(.HOLD(HOLD), .CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .en   (state_q == DRIVE),
    .last (last)
  );
  assign at_end = idx_q == IDX_W'(NUM_VEC - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    table_d = table_out;
    exp_d = exp_q;
    load = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = DRIVE;
        idx_d = '0;
        table_d = '0;
        exp_d = expected;
        load = 1'b1;
      end
      DRIVE: if (last) begin
        table_d[idx_q] = dut_out;
        idx_d = at_end ? idx_q : idx_q + 1'b1;
        state_d = at_end ? REPORT : DRIVE;
      end
      REPORT: state_d = res_ready ? IDLE : REPORT;
      default: state_d = IDLE;
    endcase
    mask_d = table_d ^ exp_d;
  end
  // Every output is a flop fed from next-state values so they all change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      exp_q <= '0;
      table_out <= '0;
      err_mask <= '0;
      pass <= 1'b0;
      in1 <= 1'b0;
      in2 <= 1'b0;
      busy <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      exp_q <= exp_d;
      table_out <= table_d;
      err_mask <= mask_d;
      pass <= (state_d == REPORT) && (mask_d == '0);
      in1 <= (state_d == DRIVE) && idx_d[1];
      in2 <= (state_d == DRIVE) && idx_d[0];
      busy <= state_d != IDLE;
      res_valid <= state_d == REPORT;
    end
  end
endmodule

// File: tb/tb_gate_tt_capture.sv
// tb_gate_tt_capture: directed checks of sweep timing, capture, compare and handshake
module tb_gate_tt_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start1 = 1'b0;
  logic [3:0] expected = 4'b0000, expected1 = 4'b0000;
  logic res_ready = 1'b1, res_ready1 = 1'b1;
  logic dut_out, dut_out1;
  logic in1, in2, busy, res_valid, pass;
  logic in1_1, in2_1, busy1, res_valid1, pass1;
  logic [3:0] table_out, err_mask, table_out1, err_mask1;
  logic [1:0] gate = 2'd0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dut_out = (gate == 2'd0) ? (in1 & in2) : (gate == 2'd1) ? (in1 ^ in2) : (in1 | in2);
  assign dut_out1 = in1_1 | in2_1;

  gate_tt_capture #(.HOLD(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_out(dut_out),
    .in1(in1), .in2(in2), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .table_out(table_out), .err_mask(err_mask), .pass(pass)
  );

  gate_tt_capture #(.HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1), .dut_out(dut_out1),
    .in1(in1_1), .in2(in2_1), .busy(busy1), .res_valid(res_valid1), .res_ready(res_ready1),
    .table_out(table_out1), .err_mask(err_mask1), .pass(pass1)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " in"}, {2'b00, in1, in2}, 4'b0000);
    chk({tag, " busy"}, {3'b000, busy}, 4'b0000);
    chk({tag, " valid"}, {3'b000, res_valid}, 4'b0000);
    chk({tag, " table"}, table_out, 4'b0000);
    chk({tag, " mask"}, err_mask, 4'b0000);
    chk({tag, " pass"}, {3'b000, pass}, 4'b0000);
  endtask

  initial begin
    tick(2);
    chk_reset("reset");
    chk("reset1 state", {busy1, res_valid1, pass1, in1_1 | in2_1}, 4'b0000);
    chk("reset1 table", table_out1, 4'b0000);
    rst_n = 1'b1;
    tick();
    // AND gate, matching expectation, consumer always ready
    gate = 2'd0; expected = 4'b1000; start = 1'b1;
    tick();
    start = 1'b0;
    chk("and e0", {busy, 1'b0, in1, in2}, 4'b1000);
    tick(9);
    chk("and k9", {2'b00, in1, in2}, 4'b0000);
    tick();
    chk("and k10", {2'b00, in1, in2}, 4'b0001);
    tick(10);
    chk("and k20", {2'b00, in1, in2}, 4'b0010);
    tick(10);
    chk("and k30", {2'b00, in1, in2}, 4'b0011);
    tick(9);
    chk("and k39", {res_valid, 1'b0, in1, in2}, 4'b0011);
    tick();
    chk("and k40 valid", {res_valid, busy, pass, 1'b0}, 4'b1110);
    chk("and table", table_out, 4'b1000);
    chk("and mask", err_mask, 4'b0000);
    tick();
    chk("and done", {res_valid, busy, in1, in2}, 4'b0000);
    chk("and table kept", table_out, 4'b1000);
    // AND gate compared against an XOR expectation
    expected = 4'b0110; start = 1'b1;
    tick();
    start = 1'b0;
    tick(40);
    chk("xor valid", {res_valid, pass, 2'b00}, 4'b1000);
    chk("xor table", table_out, 4'b1000);
    chk("xor mask", err_mask, 4'b1110);
    tick();
    chk("xor done", {res_valid, busy, 2'b00}, 4'b0000);
    // backpressure with ignored start pulses and a changing expectation
    expected = 4'b1000; res_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(40);
    chk("bp valid", {res_valid, busy, pass, 1'b0}, 4'b1110);
    for (int i = 0; i < 7; i++) begin
      start = 1'b1; expected = 4'b0000;
      tick();
      start = 1'b0;
      chk("bp hold flags", {res_valid, busy, pass, in1 | in2}, 4'b1110);
      chk("bp hold table", table_out, 4'b1000);
      chk("bp hold mask", err_mask, 4'b0000);
      tick();
    end
    res_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bp handshake", {res_valid, busy, 2'b00}, 4'b0000);
    tick();
    chk("bp no restart", {res_valid, busy, in1, in2}, 4'b0000);
    // start pulse mid-sweep has no effect on timing
    expected = 4'b1000; start = 1'b1;
    tick();
    start = 1'b0;
    tick(14);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid k15", {busy, 1'b0, in1, in2}, 4'b1001);
    tick(24);
    chk("mid k39", {res_valid, 1'b0, in1, in2}, 4'b0011);
    tick();
    chk("mid k40", {res_valid, pass, 2'b00}, 4'b1100);
    tick();
    chk("mid done", {res_valid, busy, 2'b00}, 4'b0000);
    // reset mid-sweep, then a clean XOR sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(24);
    chk("rst pre", {busy, 1'b0, in1, in2}, 4'b1010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("midrst");
    gate = 2'd1; expected = 4'b0110; start = 1'b1;
    tick();
    start = 1'b0;
    tick(39);
    chk("clean k39", {res_valid, busy, in1, in2}, 4'b0111);
    tick();
    chk("clean valid", {res_valid, pass, 2'b00}, 4'b1100);
    chk("clean table", table_out, 4'b0110);
    tick();
    // HOLD=1 instance with an OR gate
    expected1 = 4'b1110; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("h1 e0", {busy1, 1'b0, in1_1, in2_1}, 4'b1000);
    tick();
    chk("h1 k1", {busy1, 1'b0, in1_1, in2_1}, 4'b1001);
    tick();
    chk("h1 k2", {busy1, 1'b0, in1_1, in2_1}, 4'b1010);
    tick();
    chk("h1 k3", {res_valid1, 1'b0, in1_1, in2_1}, 4'b0011);
    tick();
    chk("h1 valid", {res_valid1, pass1, 2'b00}, 4'b1100);
    chk("h1 table", table_out1, 4'b1110);
    chk("h1 mask", err_mask1, 4'b0000);
    tick();
    chk("h1 done", {res_valid1, busy1, 2'b00}, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
